// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the LSU data memory: access sizes, FSM states
// and the lane-alignment error rule.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int WAIT_STATES_MAX = 15;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Illegal size, or an access that is not naturally aligned to its size.
    function automatic logic align_err(input logic [1:0] size, input logic [1:0] lane);
        return (size == 2'b11)
            || ((size == SIZE_H) && lane[0])
            || ((size == SIZE_W) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and replicated write data for stores,
// byte/half/word extraction with sign or zero extension for loads.
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rbytes[gi] = rword_i[8*gi +: 8];
    end

    assign sel_byte = rbytes[lane_i];
    assign sel_half = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Store data is replicated across lanes; the byte enables pick the live copy.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = 32'h0;
        case (size_i)
            SIZE_B: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & sel_byte[7]}}, sel_byte};
            end
            SIZE_H: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~unsigned_i & sel_half[15]}}, sel_half};
            end
            SIZE_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
            default: begin
                be_o    = 4'b0000;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_data_memory.sv
// Single-port byte-addressable data memory with a fixed-latency request/response
// handshake (IDLE -> WAIT x WAIT_STATES -> RESP) and alignment/range checking.
module lsu_data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               write_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               resp_err_q;
    logic               load_ok_q;

    logic               in_idle;
    logic               op_write;
    logic [1:0]         op_size;
    logic               op_uns;
    logic [31:0]        op_addr;
    logic [31:0]        op_wdata;
    logic               op_err;
    logic               access;
    logic               we;
    logic [AW-1:0]      idx;
    logic [3:0]         be;
    logic [31:0]        wdata_al;
    logic [31:0]        load_data;

    logic [31:0]        mem_q [DEPTH_WORDS];
    logic [31:0]        rword_q;

    // With zero wait states the memory is touched on the accepting edge itself,
    // so the live request fields are used while idle, captured ones otherwise.
    assign in_idle  = (state_q == ST_IDLE);
    assign op_write = in_idle ? req_write    : write_q;
    assign op_size  = in_idle ? req_size     : size_q;
    assign op_uns   = in_idle ? req_unsigned : uns_q;
    assign op_addr  = in_idle ? req_addr     : addr_q;
    assign op_wdata = in_idle ? req_wdata    : wdata_q;

    assign op_err = align_err(op_size, op_addr[1:0]) || (|op_addr[31:AW+2]);
    assign idx    = op_addr[AW+1:2];

    assign access = rst_n && ((WAIT_STATES == 0) ? (in_idle && req_valid)
                                                 : ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1))));
    assign we     = access && op_write && !op_err;

    lsu_lane_align u_align (
        .size_i     (op_size),
        .unsigned_i (op_uns),
        .lane_i     (op_addr[1:0]),
        .wdata_i    (op_wdata),
        .rword_i    (rword_q),
        .be_o       (be),
        .wdata_o    (wdata_al),
        .rdata_o    (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            size_q     <= SIZE_W;
            uns_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            resp_err_q <= 1'b0;
            load_ok_q  <= 1'b0;
        end else begin
            resp_err_q <= 1'b0;
            load_ok_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (WAIT_STATES == 0) begin
                            state_q    <= ST_RESP;
                            resp_err_q <= op_err;
                            load_ok_q  <= !op_write && !op_err;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(WAIT_STATES);
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q    <= ST_RESP;
                        resp_err_q <= op_err;
                        load_ok_q  <= !op_write && !op_err;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read-before-write on the commit edge; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (access) begin
            rword_q <= mem_q[idx];
            for (int i = 0; i < 4; i++) begin
                if (we && be[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_al[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = in_idle;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_err_q;
    assign resp_rdata = load_ok_q ? load_data : 32'h0;

endmodule
